// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce; optional auto-repeat under KEY_REPEAT_EN.
// Latency: 2-cycle column sync, then DEBOUNCE_TICKS+1 scan ticks from detect to key_valid (registered, 1 cycle after last tick).
// Backpressure: none; key_valid is a one-cycle strobe that must be consumed when it fires, key_code holds until next accept.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CMAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    col_meta, col_s;
  logic [1:0]    cand_row, cand_row_nxt;
  logic [1:0]    cand_col, cand_col_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    row_nxt, code_nxt;
  logic          valid_nxt, down_nxt;
  logic          key_hi;
  logic          any_low;
  logic [1:0]    row_idx, low_idx;
  logic [3:0]    row_rot;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt, rep_nxt;
`endif

  // Scan tick generator: free-running divider, tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchroniser for the asynchronous, pulled-up column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_s    <= 4'b1111;
    end else begin
      col_meta <= key_col;
      col_s    <= col_meta;
    end
  end

  // Decode helpers: candidate column level, active row index, lowest low column, next row.
  always_comb begin
    key_hi  = col_s[cand_col];
    any_low = (col_s != 4'b1111);
    row_rot = {key_row[2:0], key_row[3]};
    case (key_row)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    if (!col_s[0])      low_idx = 2'd0;
    else if (!col_s[1]) low_idx = 2'd1;
    else if (!col_s[2]) low_idx = 2'd2;
    else                low_idx = 2'd3;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= SCAN;
    else
      state <= state_nxt;
  end

  // FSM next-state logic; transitions only happen on scan ticks.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        SCAN:     if (any_low) state_nxt = DEBOUNCE;
        DEBOUNCE: begin
          if (key_hi)               state_nxt = SCAN;
          else if (cnt == DEB_LAST) state_nxt = HOLD;
        end
        HOLD:     if (key_hi) state_nxt = RELEASE;
        RELEASE: begin
          if (!key_hi)              state_nxt = HOLD;
          else if (cnt == DEB_LAST) state_nxt = SCAN;
        end
        default:  state_nxt = SCAN;
      endcase
    end
  end

  // FSM output/datapath logic: next values for row drive, candidate, counters and key outputs.
  always_comb begin
    row_nxt      = key_row;
    cand_row_nxt = cand_row;
    cand_col_nxt = cand_col;
    cnt_nxt      = cnt;
    code_nxt     = key_code;
    valid_nxt    = 1'b0;
    down_nxt     = key_down;
`ifdef KEY_REPEAT_EN
    rep_nxt      = rep_cnt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cand_row_nxt = row_idx;
            cand_col_nxt = low_idx;
            cnt_nxt      = '0;
          end else begin
            row_nxt = row_rot;
          end
        end
        DEBOUNCE: begin
          if (key_hi) begin
            row_nxt = row_rot;
          end else if (cnt == DEB_LAST) begin
            code_nxt  = {cand_row, cand_col};
            valid_nxt = 1'b1;
            down_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_nxt   = '0;
`endif
          end else if (cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HOLD: begin
          if (key_hi) begin
            cnt_nxt = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            valid_nxt = 1'b1;
            rep_nxt   = '0;
          end else begin
            rep_nxt = rep_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (key_hi) begin
            if (cnt == DEB_LAST) begin
              down_nxt = 1'b0;
              row_nxt  = row_rot;
            end else if (cnt != '1) begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_row   <= 4'b1110;
      cand_row  <= 2'd0;
      cand_col  <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_row   <= row_nxt;
      cand_row  <= cand_row_nxt;
      cand_col  <= cand_col_nxt;
      cnt       <= cnt_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_down  <= down_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter; survives RELEASE->HOLD bounces, cleared only on fresh acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_nxt;
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed tests of keypad_scan with a behavioural 4x4 key matrix.
// Timing: edges are counted from reset release; scan ticks land on every 4th edge.
// Expected repeat counts depend on whether KEY_REPEAT_EN is defined for the build.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RP = 5;
`ifdef KEY_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = 16'h0000;  // bit r*4+c = key at row r, col c held
  int          cyc;
  int          vcnt = 0;
  int          base;
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DB), .REPEAT_TICKS(RP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Count key_valid strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && key_valid) vcnt <= vcnt + 1;
  end

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!key_row[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after edge n (counted from reset release).
  task automatic at_edge(input int n);
    if (n > cyc) repeat (n - cyc) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    rst_n   = 1'b0;
    pressed = keys;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset values and idle row rotation
    do_reset(16'h0000);
    base = vcnt;
    chk("rst_row",   key_row,   4'b1110);
    chk("rst_code",  key_code,  4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down",  key_down,  1'b0);
    at_edge(3);  chk("row_e3",  key_row, 4'b1110);
    at_edge(4);  chk("row_e4",  key_row, 4'b1101);
    at_edge(8);  chk("row_e8",  key_row, 4'b1011);
    at_edge(12); chk("row_e12", key_row, 4'b0111);
    at_edge(16); chk("row_e16", key_row, 4'b1110);
    at_edge(20);
    chk("idle_valid_cnt", vcnt - base, 0);
    chk("idle_down",      key_down,    1'b0);

    // 2: key row2 col1 held ~10 ticks then released
    do_reset(16'h0200);
    base = vcnt;
    at_edge(23); chk("t2_valid_pre", key_valid, 1'b0);
                 chk("t2_down_pre",  key_down,  1'b0);
    at_edge(24); chk("t2_valid",     key_valid, 1'b1);
                 chk("t2_code",      key_code,  4'h9);
                 chk("t2_down",      key_down,  1'b1);
    at_edge(25); chk("t2_valid_1cyc", key_valid, 1'b0);
    at_edge(52); chk("t2_down_held", key_down,  1'b1);
    pressed = 16'h0000;
    at_edge(67); chk("t2_down_rel_pre", key_down, 1'b1);
    at_edge(68); chk("t2_down_rel",     key_down, 1'b0);
                 chk("t2_row_after",    key_row,  4'b0111);
    chk("t2_valid_cnt", vcnt - base, 1 + REP);

    // 3: bounce on row1 col3 for two ticks
    do_reset(16'h0080);
    base = vcnt;
    at_edge(12);
    pressed = 16'h0000;
    at_edge(15); chk("t3_row_hold", key_row, 4'b1101);
    at_edge(16); chk("t3_row_next", key_row, 4'b1011);
    at_edge(24);
    chk("t3_valid_cnt", vcnt - base, 0);
    chk("t3_down",      key_down,    1'b0);

    // 4: row0 cols 0 and 3 together, then col3 released alone
    do_reset(16'h0009);
    base = vcnt;
    at_edge(16); chk("t4_valid", key_valid, 1'b1);
                 chk("t4_code",  key_code,  4'h0);
                 chk("t4_down",  key_down,  1'b1);
    pressed = 16'h0001;
    at_edge(40); chk("t4_down_held", key_down, 1'b1);
                 chk("t4_row_held",  key_row,  4'b1110);
                 chk("t4_code_held", key_code, 4'h0);
    chk("t4_valid_cnt", vcnt - base, 1 + REP);

    // 5: reset during debounce of key 5 after an earlier key 9
    do_reset(16'h0200);
    base = vcnt;
    at_edge(24); chk("t5_first_code", key_code, 4'h9);
    pressed = 16'h0000;
    at_edge(40); chk("t5_first_up", key_down, 1'b0);
    pressed = 16'h0020;
    at_edge(58); chk("t5_code_kept", key_code, 4'h9);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_row",   key_row,   4'b1110);
    chk("t5_rst_code",  key_code,  4'h0);
    chk("t5_rst_valid", key_valid, 1'b0);
    chk("t5_rst_down",  key_down,  1'b0);
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    at_edge(40);
    chk("t5_valid_cnt", vcnt - base, 1);

    // 6: hold key B for 20 ticks past acceptance
    do_reset(16'h0800);
    base = vcnt;
    at_edge(24); chk("t6_valid",  key_valid, 1'b1);
                 chk("t6_code",   key_code,  4'hB);
    at_edge(44); chk("t6_repeat", key_valid, REP[0]);
                 chk("t6_code_rep", key_code, 4'hB);
    at_edge(104);
    pressed = 16'h0000;
    at_edge(130);
    chk("t6_valid_cnt", vcnt - base, 1 + 4 * REP);
    chk("t6_down",      key_down,    1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for the 4x4 matrix keypad that feeds code entry into the safe-box controller. It is the input-side counterpart of the LED-matrix display driver. It drives keypad rows one-hot low, samples the pulled-up column lines, and debounces press and release. It reports each accepted key as a 4-bit code with a one-cycle strobe plus a held-level flag.

## Interface
- SCAN_DIV, 50000: clk cycles per scan tick (1 ms at 50 MHz); ≥2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a press or a release; ≥1.
- REPEAT_TICKS, 250: auto-repeat interval in ticks; used only under KEY_REPEAT_EN.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_col  in  4  column inputs, active low, externally pulled up, asynchronous to clk.
- key_row  out  4  row drive, exactly one bit low; bit r low selects row r.
- key_code  out  4  last accepted key, {row[1:0], col[1:0]}.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_down  out  1  high while an accepted key is held (until release is debounced).

## Operation
- **Tick counter**
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted for one cycle when the count equals SCAN_DIV-1.
  - All sampling and row changes happen only on tick cycles.
- **Column synchroniser**
  - key_col passes through a 2-flop synchroniser (reset 4'b1111).
  - The FSM uses only the synchronised value, col_s.
- **FSM states:** SCAN, DEBOUNCE, HOLD, RELEASE. cand_row/cand_col hold the candidate key; cnt is the debounce counter.
- **SCAN, on tick:**
  - If any col_s bit is low, latch cand_row = current row and cand_col = lowest low index. Clear cnt, keep the row, go to DEBOUNCE.
  - Otherwise rotate key_row: 1110→1101→1011→0111→1110.
- **DEBOUNCE, on tick:**
  - If col_s[cand_col] is low, increment cnt. When cnt reaches DEBOUNCE_TICKS:
    - load key_code = {cand_row, cand_col};
    - pulse key_valid;
    - set key_down = 1;
    - go to HOLD.
  - If col_s[cand_col] is high, return to SCAN and advance to the next row. No pulse.
- **HOLD, on tick:** if col_s[cand_col] is high, clear cnt and go to RELEASE. Other columns and other keys are ignored (no rollover).
- **RELEASE, on tick:**
  - If col_s[cand_col] is high, increment cnt. When cnt reaches DEBOUNCE_TICKS:
    - clear key_down;
    - go to SCAN and advance the row.
  - If col_s[cand_col] goes low again, return to HOLD with no new pulse.
- **Simultaneous keys**
  - Same row: the lowest column index wins.
  - Different rows: the first row scanned wins.
- cnt saturates and never wraps. It is sized to hold max(DEBOUNCE_TICKS, REPEAT_TICKS).

## Timing
- **Reset values:**
  - key_row = 4'b1110, key_code = 4'h0, key_valid = 0, key_down = 0;
  - state SCAN, all counters 0, synchroniser 4'b1111.
- rst_n assertion at any point aborts the operation immediately. A pending debounce never produces key_valid.
- Column input to col_s latency: 2 cycles.
- Each row is driven for SCAN_DIV cycles before it is sampled, which gives the column lines time to settle.
- **Press event:**
  - key_valid is high for exactly one cycle, the cycle after the DEBOUNCE_TICKS-th qualifying tick.
  - key_code and key_down update on that same edge.
  - key_code holds its value until the next accepted key.
- key_down falls on the edge after the DEBOUNCE_TICKS-th high tick in RELEASE.
- Minimum press-to-strobe latency: DEBOUNCE_TICKS+1 ticks (the detect tick plus DEBOUNCE_TICKS qualifying ticks), plus up to 4 ticks of scan alignment and 2 sync cycles.

## Configuration
- **KEY_REPEAT_EN defined:**
  - In HOLD, a repeat counter increments on each tick.
  - After REPEAT_TICKS ticks of continuous hold, key_valid pulses again with the same key_code. This repeats every REPEAT_TICKS ticks.
  - The counter clears on entry to HOLD and is not cleared by a RELEASE→HOLD return.
- **KEY_REPEAT_EN undefined:** exactly one key_valid per debounced press. REPEAT_TICKS is unused.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5.

1. Reset, no keys, run 20 cycles → key_row=1110 after reset, then 1101, 1011, 0111, 1110 on successive ticks (every 4 cycles). key_valid and key_down stay 0.
2. Hold row 2 col 1 (key_col[1]=0 while key_row[2]=0) for 10 ticks, then release → exactly one key_valid with key_code=4'h9. key_down is high from the strobe until 3 ticks after release.
3. Bounce: row 1 col 3 low for 2 ticks, then high → no key_valid, key_down stays 0, scanning resumes at row 2.
4. Row 0 cols 0 and 3 pressed together → key_code=4'h0. Releasing col 3 alone has no effect, and key_down stays 1.
5. Assert rst_n low during DEBOUNCE of key 4'h5 → no key_valid. key_row=1110 and key_code=0 immediately.
6. With KEY_REPEAT_EN, hold key 4'hB for 20 ticks past acceptance → key_valid pulses at acceptance and then every 5 ticks (5 pulses total). Without the macro → 1 pulse.
